// File: rtl/reg_file_pkg.sv
// Shared definitions for the parametrised register file.
//  - default data/address widths
//  - clear-sequencer state encoding (ST_CLEAR = 0, ST_READY = 1)
//  - idx(): base bit offset of lane `port` inside a flattened bus of `width`-bit lanes
package reg_file_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    function automatic int idx(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per register, set when decode reserves a
// destination and cleared when writeback writes it.
// Ports:
//  clk       rising-edge clock
//  flush     synchronous clear of every pending bit
//  set_en    reserve strobe, set_addr marks the bit pending
//  clr_en    write strobe, clr_addr clears the bit
//  lk_addr   NREAD flattened lookup addresses, lane i at [i*ADDR_W +: ADDR_W]
//  lk_pend   NREAD combinational pending bits for the lookup addresses
module reg_scoreboard
    import reg_file_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NREAD  = 2
) (
    input  logic                    clk,
    input  logic                    flush,
    input  logic                    set_en,
    input  logic [ADDR_W-1:0]       set_addr,
    input  logic                    clr_en,
    input  logic [ADDR_W-1:0]       clr_addr,
    input  logic [NREAD*ADDR_W-1:0] lk_addr,
    output logic [NREAD-1:0]        lk_pend
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0] pend_reg;

    // The set is applied after the clear so that a reserve and a write to the
    // same register in one cycle leave it pending: the newer writer is still
    // outstanding.
    always_ff @(posedge clk) begin
        if (flush) begin
            pend_reg <= '0;
        end else begin
            if (clr_en) begin
                pend_reg[clr_addr] <= 1'b0;
            end
            if (set_en) begin
                pend_reg[set_addr] <= 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NREAD; gi++) begin : g_lookup
            assign lk_pend[gi] = pend_reg[lk_addr[idx(gi, ADDR_W) +: ADDR_W]];
        end
    endgenerate

endmodule

// File: rtl/reg_file_np.sv
// N-read / 1-write register file with optional hardwired-zero register 0,
// write-first bypass, pending-write scoreboard, registered debug read port and
// a reset-triggered clear sequencer.
// Ports:
//  clk, reset     clock and synchronous active-high reset (starts clearing)
//  ready          1 once every register has been cleared
//  RegWrite, wrAddr, wrData   writeback port
//  rsvEn, rsvAddr             decode reservation of a destination register
//  rdAddr / rdData / rdPend   NREAD combinational read lanes (flattened)
//  dbgAddr / dbgData          debug read, one cycle latency
module reg_file_np
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic                    ready,
    input  logic                    RegWrite,
    input  logic [ADDR_W-1:0]       wrAddr,
    input  logic [DATA_W-1:0]       wrData,
    input  logic                    rsvEn,
    input  logic [ADDR_W-1:0]       rsvAddr,
    input  logic [NREAD*ADDR_W-1:0] rdAddr,
    output logic [NREAD*DATA_W-1:0] rdData,
    output logic [NREAD-1:0]        rdPend,
    input  logic [ADDR_W-1:0]       dbgAddr,
    output logic [DATA_W-1:0]       dbgData
);

    localparam int DEPTH   = 2 ** ADDR_W;
    localparam bit ZERO_ON = (ZERO_REG != 0);

    // ------------------------------------------------------------------
    // Clear sequencer
    // ------------------------------------------------------------------
    state_t              state_reg;
    logic [ADDR_W-1:0]   clr_cnt_reg;
    logic                is_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_CLEAR;
            clr_cnt_reg <= '0;
        end else begin
            case (state_reg)
                ST_CLEAR: begin
                    clr_cnt_reg <= clr_cnt_reg + 1'b1;
                    if (clr_cnt_reg == ADDR_W'(DEPTH - 1)) begin
                        state_reg <= ST_READY;
                    end
                end
                ST_READY: begin
                    state_reg <= ST_READY;
                end
                default: begin
                    state_reg <= ST_CLEAR;
                end
            endcase
        end
    end

    assign is_ready = (state_reg == ST_READY);
    assign ready    = is_ready;

    // ------------------------------------------------------------------
    // Qualified write / reserve requests (zero register drops both)
    // ------------------------------------------------------------------
    logic wr_zero;
    logic rsv_zero;
    logic wr_ok;
    logic rsv_ok;

    assign wr_zero  = ZERO_ON && (wrAddr == '0);
    assign rsv_zero = ZERO_ON && (rsvAddr == '0);
    assign wr_ok    = is_ready && RegWrite && !wr_zero;
    assign rsv_ok   = is_ready && rsvEn && !rsv_zero;

    // ------------------------------------------------------------------
    // Register array: single write port shared by the sequencer and
    // writeback, no per-entry reset.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem [DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wrAddr;
        mem_wdata = wrData;
        if (!reset) begin
            if (state_reg == ST_CLEAR) begin
                mem_we    = 1'b1;
                mem_waddr = clr_cnt_reg;
                mem_wdata = '0;
            end else if (wr_ok) begin
                mem_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    logic [NREAD-1:0] sb_pend;

    reg_scoreboard #(
        .ADDR_W (ADDR_W),
        .NREAD  (NREAD)
    ) u_scoreboard (
        .clk      (clk),
        .flush    (reset),
        .set_en   (rsv_ok),
        .set_addr (rsvAddr),
        .clr_en   (wr_ok),
        .clr_addr (wrAddr),
        .lk_addr  (rdAddr),
        .lk_pend  (sb_pend)
    );

    // ------------------------------------------------------------------
    // Read lanes with write-first bypass
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NREAD; gi++) begin : g_read
            logic [ADDR_W-1:0] ra;
            logic [DATA_W-1:0] rd;
            logic              rp;
            logic              zero_hit;
            logic              wr_hit;
            logic              rsv_hit;

            assign ra       = rdAddr[idx(gi, ADDR_W) +: ADDR_W];
            assign zero_hit = ZERO_ON && (ra == '0);
            assign wr_hit   = RegWrite && (wrAddr == ra);
            assign rsv_hit  = rsvEn && (rsvAddr == ra);

            always_comb begin
                rd = '0;
                rp = 1'b0;
                if (is_ready && !zero_hit) begin
                    if (wr_hit) begin
                        // Forward the data being written; a same-cycle
                        // reserve means a newer writer is still outstanding.
                        rd = wrData;
                        rp = rsv_hit;
                    end else begin
                        rd = mem[ra];
                        rp = sb_pend[gi];
                    end
                end
            end

            assign rdData[idx(gi, DATA_W) +: DATA_W] = rd;
            assign rdPend[gi]                        = rp;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Debug read port: same bypass and zero rules, registered.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] dbg_next;
    logic [DATA_W-1:0] dbg_reg;

    always_comb begin
        dbg_next = '0;
        if (!(ZERO_ON && (dbgAddr == '0))) begin
            if (RegWrite && (wrAddr == dbgAddr)) begin
                dbg_next = wrData;
            end else begin
                dbg_next = mem[dbgAddr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !is_ready) begin
            dbg_reg <= '0;
        end else begin
            dbg_reg <= dbg_next;
        end
    end

    assign dbgData = dbg_reg;

endmodule

// File: tb/tb_reg_file_np.sv
module tb_reg_file_np;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Instance A: defaults (32x32, 2 read ports, zero register on)
    logic        a_reset, a_ready, a_we, a_rsv_en;
    logic [4:0]  a_wr_addr, a_rsv_addr, a_dbg_addr;
    logic [31:0] a_wr_data, a_dbg_data;
    logic [9:0]  a_rd_addr;
    logic [63:0] a_rd_data;
    logic [1:0]  a_rd_pend;

    // Instance B: 16x16, 3 read ports, zero register off
    logic        b_reset, b_ready, b_we, b_rsv_en;
    logic [3:0]  b_wr_addr, b_rsv_addr, b_dbg_addr;
    logic [15:0] b_wr_data, b_dbg_data;
    logic [11:0] b_rd_addr;
    logic [47:0] b_rd_data;
    logic [2:0]  b_rd_pend;

    reg_file_np dut_a (
        .clk      (clk),
        .reset    (a_reset),
        .ready    (a_ready),
        .RegWrite (a_we),
        .wrAddr   (a_wr_addr),
        .wrData   (a_wr_data),
        .rsvEn    (a_rsv_en),
        .rsvAddr  (a_rsv_addr),
        .rdAddr   (a_rd_addr),
        .rdData   (a_rd_data),
        .rdPend   (a_rd_pend),
        .dbgAddr  (a_dbg_addr),
        .dbgData  (a_dbg_data)
    );

    reg_file_np #(
        .DATA_W   (16),
        .ADDR_W   (4),
        .NREAD    (3),
        .ZERO_REG (0)
    ) dut_b (
        .clk      (clk),
        .reset    (b_reset),
        .ready    (b_ready),
        .RegWrite (b_we),
        .wrAddr   (b_wr_addr),
        .wrData   (b_wr_data),
        .rsvEn    (b_rsv_en),
        .rsvAddr  (b_rsv_addr),
        .rdAddr   (b_rd_addr),
        .rdData   (b_rd_data),
        .rdPend   (b_rd_pend),
        .dbgAddr  (b_dbg_addr),
        .dbgData  (b_dbg_data)
    );

    // Advance one rising edge and land 2 ns after it.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        a_reset = 1'b1;
        b_reset = 1'b1;
        step();
        tests++;
        if (a_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_ready got=%0b exp=0", a_ready);
        end
        a_reset = 1'b0;
        b_reset = 1'b0;
        repeat (32) step();
        tests++;
        if (a_ready !== 1'b1) begin
            fails++;
            $display("FAIL first_clear_ready got=%0b exp=1", a_ready);
        end
        // Seed r3 so a write leaking through during the next clear is visible.
        a_we = 1'b1; a_wr_addr = 5'd3; a_wr_data = 32'h0000AAAA;
        step();
        a_we = 1'b0;
        a_rd_addr = {5'd0, 5'd3};
        #1;
        tests++;
        if (a_rd_data[31:0] !== 32'h0000AAAA) begin
            fails++;
            $display("FAIL seed_r3 got=%h exp=0000aaaa", a_rd_data[31:0]);
        end
        // Clear again while writeback keeps hammering r3.
        a_reset = 1'b1;
        step();
        a_reset = 1'b0;
        a_we = 1'b1; a_wr_addr = 5'd3; a_wr_data = 32'h00001111;
        for (int k = 1; k <= 31; k++) begin
            step();
            tests++;
            if (a_ready !== 1'b0 || a_rd_data !== 64'd0 || a_rd_pend !== 2'b00) begin
                fails++;
                $display("FAIL clear_edge%0d ready=%0b data=%h pend=%b exp ready=0 data=0 pend=0",
                         k, a_ready, a_rd_data, a_rd_pend);
            end
        end
        step();
        tests++;
        if (a_ready !== 1'b1) begin
            fails++;
            $display("FAIL ready_at_32 got=%0b exp=1", a_ready);
        end
        a_we = 1'b0;
        for (int a = 0; a < 32; a++) begin
            a_rd_addr = {5'(a), 5'(a)};
            #1;
            tests++;
            if (a_rd_data !== 64'd0 || a_rd_pend !== 2'b00) begin
                fails++;
                $display("FAIL cleared_r%0d data=%h pend=%b exp data=0 pend=0", a, a_rd_data, a_rd_pend);
            end
        end
        $display("[TB] reset/clear sequence checked");
    endtask

    task automatic test_bypass();
        step();
        a_we = 1'b1; a_wr_addr = 5'd5; a_wr_data = 32'hDEADBEEF;
        a_rd_addr = {5'd6, 5'd5};
        #1;
        tests++;
        if (a_rd_data !== {32'd0, 32'hDEADBEEF} || a_rd_pend !== 2'b00) begin
            fails++;
            $display("FAIL bypass_r5 data=%h pend=%b exp data=00000000deadbeef pend=00", a_rd_data, a_rd_pend);
        end
        step();
        a_we = 1'b0;
        #1;
        tests++;
        if (a_rd_data[31:0] !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL array_r5 got=%h exp=deadbeef", a_rd_data[31:0]);
        end
        $display("[TB] bypass write r5 checked");
    endtask

    task automatic test_zero_reg();
        a_we = 1'b1; a_wr_addr = 5'd0; a_wr_data = 32'h00001234;
        a_rsv_en = 1'b1; a_rsv_addr = 5'd0;
        a_rd_addr = {5'd0, 5'd0};
        #1;
        tests++;
        if (a_rd_data !== 64'd0 || a_rd_pend !== 2'b00) begin
            fails++;
            $display("FAIL zero_bypass data=%h pend=%b exp data=0 pend=00", a_rd_data, a_rd_pend);
        end
        step();
        a_we = 1'b0; a_rsv_en = 1'b0;
        #1;
        tests++;
        if (a_rd_data !== 64'd0 || a_rd_pend !== 2'b00) begin
            fails++;
            $display("FAIL zero_after data=%h pend=%b exp data=0 pend=00", a_rd_data, a_rd_pend);
        end
        $display("[TB] zero register (ZERO_REG=1) checked");
    endtask

    task automatic test_zero_off();
        step();
        b_we = 1'b1; b_wr_addr = 4'd0; b_wr_data = 16'h1234;
        b_rsv_en = 1'b1; b_rsv_addr = 4'd0;
        b_rd_addr = {4'd0, 4'd0, 4'd0};
        #1;
        tests++;
        if (b_rd_data[15:0] !== 16'h1234 || b_rd_pend[0] !== 1'b1) begin
            fails++;
            $display("FAIL r0_ordinary_bypass data=%h pend=%b exp data=1234 pend=1", b_rd_data[15:0], b_rd_pend[0]);
        end
        step();
        b_we = 1'b0; b_rsv_en = 1'b0;
        #1;
        tests++;
        if (b_rd_data[15:0] !== 16'h1234 || b_rd_pend[0] !== 1'b1) begin
            fails++;
            $display("FAIL r0_ordinary_array data=%h pend=%b exp data=1234 pend=1", b_rd_data[15:0], b_rd_pend[0]);
        end
        $display("[TB] r0 as ordinary register (ZERO_REG=0) checked");
    endtask

    task automatic test_scoreboard();
        step();
        a_rsv_en = 1'b1; a_rsv_addr = 5'd7;
        a_rd_addr = {5'd0, 5'd7};
        #1;
        tests++;
        if (a_rd_pend[0] !== 1'b0) begin
            fails++;
            $display("FAIL rsv_not_yet got=%0b exp=0", a_rd_pend[0]);
        end
        step();
        a_rsv_en = 1'b0;
        #1;
        tests++;
        if (a_rd_pend[0] !== 1'b1) begin
            fails++;
            $display("FAIL rsv_pending got=%0b exp=1", a_rd_pend[0]);
        end
        a_we = 1'b1; a_wr_addr = 5'd7; a_wr_data = 32'h00000055;
        #1;
        tests++;
        if (a_rd_pend[0] !== 1'b0 || a_rd_data[31:0] !== 32'h00000055) begin
            fails++;
            $display("FAIL wr_bypass_r7 pend=%0b data=%h exp pend=0 data=00000055", a_rd_pend[0], a_rd_data[31:0]);
        end
        step();
        a_we = 1'b0;
        #1;
        tests++;
        if (a_rd_pend[0] !== 1'b0 || a_rd_data[31:0] !== 32'h00000055) begin
            fails++;
            $display("FAIL wr_done_r7 pend=%0b data=%h exp pend=0 data=00000055", a_rd_pend[0], a_rd_data[31:0]);
        end
        a_we = 1'b1; a_wr_data = 32'h00000066;
        a_rsv_en = 1'b1; a_rsv_addr = 5'd7;
        #1;
        tests++;
        if (a_rd_pend[0] !== 1'b1) begin
            fails++;
            $display("FAIL rsv_wr_same_comb got=%0b exp=1", a_rd_pend[0]);
        end
        step();
        a_we = 1'b0; a_rsv_en = 1'b0;
        #1;
        tests++;
        if (a_rd_pend[0] !== 1'b1 || a_rd_data[31:0] !== 32'h00000066) begin
            fails++;
            $display("FAIL rsv_wins_r7 pend=%0b data=%h exp pend=1 data=00000066", a_rd_pend[0], a_rd_data[31:0]);
        end
        $display("[TB] scoreboard reserve/write on r7 checked");
    endtask

    task automatic test_reset_restart();
        a_dbg_addr = 5'd5;
        step();
        tests++;
        if (a_dbg_data !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL dbg_r5 got=%h exp=deadbeef", a_dbg_data);
        end
        a_reset = 1'b1;
        step();
        a_reset = 1'b0;
        repeat (10) step();
        a_reset = 1'b1;
        step();
        tests++;
        if (a_dbg_data !== 32'd0 || a_ready !== 1'b0) begin
            fails++;
            $display("FAIL restart_reset dbg=%h ready=%0b exp dbg=0 ready=0", a_dbg_data, a_ready);
        end
        a_reset = 1'b0;
        for (int k = 1; k <= 31; k++) begin
            step();
            tests++;
            if (a_ready !== 1'b0 || a_dbg_data !== 32'd0) begin
                fails++;
                $display("FAIL restart_edge%0d ready=%0b dbg=%h exp ready=0 dbg=0", k, a_ready, a_dbg_data);
            end
        end
        step();
        tests++;
        if (a_ready !== 1'b1) begin
            fails++;
            $display("FAIL restart_ready got=%0b exp=1", a_ready);
        end
        a_rd_addr = {5'd5, 5'd7};
        #1;
        tests++;
        if (a_rd_pend !== 2'b00 || a_rd_data !== 64'd0) begin
            fails++;
            $display("FAIL restart_pend pend=%b data=%h exp pend=00 data=0", a_rd_pend, a_rd_data);
        end
        step();
        tests++;
        if (a_dbg_data !== 32'd0) begin
            fails++;
            $display("FAIL restart_dbg got=%h exp=0", a_dbg_data);
        end
        $display("[TB] reset restart mid-clear checked");
    endtask

    task automatic test_multi_port();
        b_we = 1'b1;
        b_wr_addr = 4'd1; b_wr_data = 16'h1111; step();
        b_wr_addr = 4'd2; b_wr_data = 16'h2222; step();
        b_wr_addr = 4'd9; b_wr_data = 16'h9999; step();
        b_we = 1'b0;
        b_rd_addr = {4'd9, 4'd2, 4'd1};
        #1;
        tests++;
        if (b_rd_data !== {16'h9999, 16'h2222, 16'h1111} || b_rd_pend !== 3'b000) begin
            fails++;
            $display("FAIL distinct data=%h pend=%b exp data=999922221111 pend=000", b_rd_data, b_rd_pend);
        end
        b_rd_addr = {4'd2, 4'd2, 4'd2};
        #1;
        tests++;
        if (b_rd_data !== {16'h2222, 16'h2222, 16'h2222}) begin
            fails++;
            $display("FAIL identical got=%h exp=222222222222", b_rd_data);
        end
        b_rd_addr = {4'd0, 4'd0, 4'd0};
        #1;
        tests++;
        if (b_rd_data !== {16'h1234, 16'h1234, 16'h1234} || b_rd_pend !== 3'b111) begin
            fails++;
            $display("FAIL r0_all data=%h pend=%b exp data=123412341234 pend=111", b_rd_data, b_rd_pend);
        end
        b_dbg_addr = 4'd9;
        step();
        tests++;
        if (b_dbg_data !== 16'h9999) begin
            fails++;
            $display("FAIL dbg_r9 got=%h exp=9999", b_dbg_data);
        end
        b_we = 1'b1; b_wr_addr = 4'd9; b_wr_data = 16'hABCD;
        step();
        b_we = 1'b0;
        tests++;
        if (b_dbg_data !== 16'hABCD) begin
            fails++;
            $display("FAIL dbg_bypass_r9 got=%h exp=abcd", b_dbg_data);
        end
        $display("[TB] 3-port 16x16 reads and debug port checked");
    endtask

    initial begin
        a_reset = 1'b1; a_we = 1'b0; a_wr_addr = '0; a_wr_data = '0;
        a_rsv_en = 1'b0; a_rsv_addr = '0; a_rd_addr = '0; a_dbg_addr = '0;
        b_reset = 1'b1; b_we = 1'b0; b_wr_addr = '0; b_wr_data = '0;
        b_rsv_en = 1'b0; b_rsv_addr = '0; b_rd_addr = '0; b_dbg_addr = '0;
        step();
        test_reset();
        test_bypass();
        test_zero_reg();
        test_zero_off();
        test_scoreboard();
        test_reset_restart();
        test_multi_port();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
